// File: rtl/disp_capture.sv
// ---------------------------------------------------------------------------
// disp_capture
//   Capture front end for the display pixel interface. Samples the DSP_*
//   pins once in the DCLK domain, aligns to a VSYNC fall, packs pairs of
//   24-bit pixels into 64-bit frame-buffer words and presents them on a
//   one-deep valid/ready output register. Line/frame geometry is checked
//   against RESOL and reported through sticky error flags.
//
// Ports
//   DCLK, ARESETN             pixel clock, async active-low reset
//   RESOL[1:0]                00 VGA, 01 XGA, 10 SXGA, 11 VGA
//   CAP_ENABLE, ERR_CLR       capture request level, sticky-error clear pulse
//   DSP_R/G/B, DSP_DE         pixel data and active-video qualifier
//   DSP_HSYNC_X, DSP_VSYNC_X  active-low syncs
//   CAP_DATA/VALID/READY      output word stream {0,R1,G1,B1,0,R0,G0,B0}
//   CAP_SOF, CAP_EOL          first word of frame / last word of line
//   CAP_BUSY, FRAME_CNT       capturing, completed-frame count
//   HSIZE_ERR, VSIZE_ERR,
//   OVERFLOW                  sticky geometry and drop errors
// ---------------------------------------------------------------------------
module disp_capture #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_CNT_WIDTH  = 11
) (
  input  logic                    DCLK,
  input  logic                    ARESETN,
  input  logic [1:0]              RESOL,
  input  logic                    CAP_ENABLE,
  input  logic                    ERR_CLR,
  input  logic [7:0]              DSP_R,
  input  logic [7:0]              DSP_G,
  input  logic [7:0]              DSP_B,
  input  logic                    DSP_DE,
  input  logic                    DSP_HSYNC_X,
  input  logic                    DSP_VSYNC_X,
  output logic [C_DATA_WIDTH-1:0] CAP_DATA,
  output logic                    CAP_VALID,
  input  logic                    CAP_READY,
  output logic                    CAP_SOF,
  output logic                    CAP_EOL,
  output logic                    CAP_BUSY,
  output logic [7:0]              FRAME_CNT,
  output logic                    HSIZE_ERR,
  output logic                    VSIZE_ERR,
  output logic                    OVERFLOW
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_e;

  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

  // Input stage (S1)
  logic [23:0] rgb_s1_q;
  logic        de_s1_q, hs_s1_q, vs_s1_q;
  logic        de_prev_q, vs_prev_q;

  // Control state
  state_e                 state_q, state_d;
  logic [C_CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [C_CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [23:0]            lo_q, lo_d;
  logic                   sof_arm_q, sof_arm_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;

  // Output register and sticky flags
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    sof_q, sof_d;
  logic                    eol_q, eol_d;
  logic                    hsize_q, hsize_d;
  logic                    vsize_q, vsize_d;
  logic                    ovf_q, ovf_d;

  // Per-cycle events
  logic [C_CNT_WIDTH-1:0]  exp_w, exp_h;
  logic                    vs_fall, de_fall;
  logic                    word_new, word_sof, word_eol;
  logic [C_DATA_WIDTH-1:0] word_data;
  logic                    hsize_ev, vsize_ev, ovf_ev;

  // HSYNC is sampled with the other pins for alignment, but line boundaries
  // are taken from DE, so the sampled value has no consumer.
  logic s1_hs_unused;
  assign s1_hs_unused = hs_s1_q;

  always_comb begin
    case (RESOL)
      2'b01:   begin exp_w = C_CNT_WIDTH'(1024); exp_h = C_CNT_WIDTH'(768);  end
      2'b10:   begin exp_w = C_CNT_WIDTH'(1280); exp_h = C_CNT_WIDTH'(1024); end
      default: begin exp_w = C_CNT_WIDTH'(640);  exp_h = C_CNT_WIDTH'(480);  end
    endcase
  end

  assign vs_fall = vs_prev_q & ~vs_s1_q;
  assign de_fall = de_prev_q & ~de_s1_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge DCLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rgb_s1_q  <= '0;
      de_s1_q   <= 1'b0;
      hs_s1_q   <= 1'b1;
      vs_s1_q   <= 1'b1;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b1;
    end else begin
      rgb_s1_q  <= {DSP_R, DSP_G, DSP_B};
      de_s1_q   <= DSP_DE;
      hs_s1_q   <= DSP_HSYNC_X;
      vs_s1_q   <= DSP_VSYNC_X;
      de_prev_q <= de_s1_q;
      vs_prev_q <= vs_s1_q;
    end
  end

  // Capture FSM, pixel packing and geometry counters
  always_comb begin
    // NOTE: every signal written here gets its default first, so no branch
    // leaves one unassigned and no latch can be inferred.
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    lo_d        = lo_q;
    sof_arm_d   = sof_arm_q;
    frame_cnt_d = frame_cnt_q;
    word_new    = 1'b0;
    word_data   = '0;
    word_sof    = 1'b0;
    word_eol    = 1'b0;
    hsize_ev    = 1'b0;
    vsize_ev    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CAP_ENABLE) state_d = ST_WAIT_VS;
      end

      ST_WAIT_VS: begin
        if (!CAP_ENABLE) begin
          state_d = ST_IDLE;
        end else if (vs_fall) begin
          state_d    = ST_ACTIVE;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          sof_arm_d  = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (de_s1_q) begin
          if (!pix_cnt_q[0]) begin
            lo_d = rgb_s1_q;
          end else begin
            word_new  = 1'b1;
            word_data = {8'h00, rgb_s1_q, 8'h00, lo_q};
            word_eol  = (pix_cnt_q == exp_w - 1'b1);
          end
          pix_cnt_d = (pix_cnt_q == CNT_MAX) ? pix_cnt_q : pix_cnt_q + 1'b1;
        end else if (de_fall) begin
          // An odd-length line leaves a half word; flush it zero-padded.
          if (pix_cnt_q[0]) begin
            word_new  = 1'b1;
            word_data = {32'h0, 8'h00, lo_q};
            word_eol  = 1'b1;
          end
          hsize_ev   = (pix_cnt_q != exp_w);
          line_cnt_d = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + 1'b1;
          pix_cnt_d  = '0;
        end

        // SOF rides on the first word generated after arming, even if that
        // word is then dropped by a full output register.
        if (word_new) begin
          word_sof  = sof_arm_q;
          sof_arm_d = 1'b0;
        end

        // End of frame; CAP_ENABLE is only honoured here.
        if (vs_fall) begin
          vsize_ev    = (line_cnt_q != exp_h);
          frame_cnt_d = frame_cnt_q + 8'd1;
          line_cnt_d  = '0;
          if (!CAP_ENABLE) state_d = ST_IDLE;
          else             sof_arm_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // One-deep output register and sticky error flags
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    ovf_ev  = 1'b0;

    if (valid_q && CAP_READY) valid_d = 1'b0;

    if (word_new) begin
      if (!valid_q || CAP_READY) begin
        valid_d = 1'b1;
        data_d  = word_data;
        sof_d   = word_sof;
        eol_d   = word_eol;
      end else begin
        ovf_ev = 1'b1;
      end
    end

    // A new error event wins over a coincident clear.
    hsize_d = (hsize_q && !ERR_CLR) || hsize_ev;
    vsize_d = (vsize_q && !ERR_CLR) || vsize_ev;
    ovf_d   = (ovf_q   && !ERR_CLR) || ovf_ev;
  end

  always_ff @(posedge DCLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      lo_q        <= '0;
      sof_arm_q   <= 1'b0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      hsize_q     <= 1'b0;
      vsize_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      lo_q        <= lo_d;
      sof_arm_q   <= sof_arm_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      hsize_q     <= hsize_d;
      vsize_q     <= vsize_d;
      ovf_q       <= ovf_d;
    end
  end

  assign CAP_DATA  = data_q;
  assign CAP_VALID = valid_q;
  assign CAP_SOF   = sof_q;
  assign CAP_EOL   = eol_q;
  assign CAP_BUSY  = (state_q == ST_ACTIVE);
  assign FRAME_CNT = frame_cnt_q;
  assign HSIZE_ERR = hsize_q;
  assign VSIZE_ERR = vsize_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_disp_capture.sv
// ---------------------------------------------------------------------------
// tb_disp_capture
//   Randomized scoreboard bench for disp_capture. A line-level reference
//   model predicts the packed words (pushed into a queue) and the sticky
//   flags / frame count; a separate monitor pops and compares every word the
//   DUT hands over on CAP_VALID && CAP_READY.
// ---------------------------------------------------------------------------
module tb_disp_capture;

  logic        DCLK = 1'b0;
  logic        ARESETN;
  logic [1:0]  RESOL;
  logic        CAP_ENABLE, ERR_CLR;
  logic [7:0]  DSP_R, DSP_G, DSP_B;
  logic        DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X;
  logic [63:0] CAP_DATA;
  logic        CAP_VALID, CAP_READY, CAP_SOF, CAP_EOL, CAP_BUSY;
  logic [7:0]  FRAME_CNT;
  logic        HSIZE_ERR, VSIZE_ERR, OVERFLOW;

  disp_capture #(.C_DATA_WIDTH(64), .C_CNT_WIDTH(11)) dut (
    .DCLK(DCLK), .ARESETN(ARESETN), .RESOL(RESOL), .CAP_ENABLE(CAP_ENABLE),
    .ERR_CLR(ERR_CLR), .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B),
    .DSP_DE(DSP_DE), .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X),
    .CAP_DATA(CAP_DATA), .CAP_VALID(CAP_VALID), .CAP_READY(CAP_READY),
    .CAP_SOF(CAP_SOF), .CAP_EOL(CAP_EOL), .CAP_BUSY(CAP_BUSY),
    .FRAME_CNT(FRAME_CNT), .HSIZE_ERR(HSIZE_ERR), .VSIZE_ERR(VSIZE_ERR),
    .OVERFLOW(OVERFLOW)
  );

  always #5 DCLK = ~DCLK;

  typedef struct {
    logic [63:0] data;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random single-cycle gaps, 2: held low

  // Reference model state (line/frame granularity)
  bit         m_active  = 1'b0;
  bit         m_sof_arm = 1'b0;
  int         m_lines   = 0;
  logic [7:0] m_frames  = 8'd0;
  bit         m_hsize = 1'b0, m_vsize = 1'b0, m_ovf = 1'b0;

  function automatic int exp_w(input logic [1:0] r);
    case (r)
      2'b01:   return 1024;
      2'b10:   return 1280;
      default: return 640;
    endcase
  endfunction

  function automatic int exp_h(input logic [1:0] r);
    case (r)
      2'b01:   return 768;
      2'b10:   return 1024;
      default: return 480;
    endcase
  endfunction

  // Ramp stimulus: R = x, G = y, B = x ^ y
  function automatic logic [23:0] pix(input int x, input int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return {xb, yb, xb ^ yb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready generator. Gaps are never longer than one cycle, so with words at
  // most every second cycle the one-deep register never has to drop.
  initial begin
    bit was_low = 1'b0;
    CAP_READY = 1'b1;
    forever begin
      @(posedge DCLK);
      #1;
      case (ready_mode)
        0:       CAP_READY = 1'b1;
        1:       CAP_READY = was_low ? 1'b1 : ($urandom_range(0, 3) != 0);
        default: CAP_READY = 1'b0;
      endcase
      was_low = !CAP_READY;
    end
  end

  // Monitor: compare each handed-over word against the scoreboard head.
  initial begin
    forever begin
      @(negedge DCLK);
      if (ARESETN === 1'b1 && CAP_VALID === 1'b1 && CAP_READY === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h expected none", CAP_DATA);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", CAP_DATA, mon_e.data);
          check("word_sof", 64'(CAP_SOF), 64'(mon_e.sof));
          check("word_eol", 64'(CAP_EOL), 64'(mon_e.eol));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive one DCLK cycle of pin values; returns 1 ns after the capturing edge.
  task automatic put(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
    DSP_DE      = de;
    DSP_HSYNC_X = hs;
    DSP_VSYNC_X = vs;
    {DSP_R, DSP_G, DSP_B} = rgb;
    @(posedge DCLK);
    #1;
  endtask

  task automatic model_clear();
    m_hsize = 1'b0;
    m_vsize = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic err_clr_pulse();
    ERR_CLR = 1'b1;
    put(1'b0, 1'b1, 1'b1, 24'h0);
    ERR_CLR = 1'b0;
    model_clear();
    repeat (2) put(1'b0, 1'b1, 1'b1, 24'h0);
  endtask

  // VSYNC pulse: start of capture when waiting, end of frame when capturing.
  task automatic vs_fall();
    if (m_active) begin
      if (m_lines != exp_h(RESOL)) m_vsize = 1'b1;
      m_frames = m_frames + 8'd1;
      m_lines  = 0;
      if (!CAP_ENABLE) m_active = 1'b0;
      else             m_sof_arm = 1'b1;
    end else if (CAP_ENABLE) begin
      m_active  = 1'b1;
      m_lines   = 0;
      m_sof_arm = 1'b1;
    end
    repeat (3) put(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (3) put(1'b0, 1'b1, 1'b1, 24'h0);
  endtask

  // One line of w pixels on row y. stall holds CAP_READY low for the line;
  // clr pulses ERR_CLR together with the first blank after the pixels, i.e.
  // on the edge where the line's last pair (if even) completes.
  task automatic send_line(input int w, input int y, input bit stall, input bit clr);
    exp_t        e;
    int          n, k;
    logic [23:0] lo, hi;
    put(1'b0, 1'b0, 1'b1, 24'h0);
    put(1'b0, 1'b0, 1'b1, 24'h0);
    put(1'b0, 1'b1, 1'b1, 24'h0);
    put(1'b0, 1'b1, 1'b1, 24'h0);
    if (stall) begin
      ready_mode = 2;
      repeat (2) put(1'b0, 1'b1, 1'b1, 24'h0);
    end
    if (m_active) begin
      n = (w + 1) / 2;
      for (int j = 0; j < n; j++) begin
        k  = 2 * j;
        lo = pix(k, y);
        hi = (k + 1 < w) ? pix(k + 1, y) : 24'h0;
        e.data = {8'h00, hi, 8'h00, lo};
        e.eol  = (k + 1 < w) ? (k + 1 == exp_w(RESOL) - 1) : 1'b1;
        e.sof  = m_sof_arm;
        m_sof_arm = 1'b0;
        if (clr && j == n - 1) model_clear();
        if (stall && j > 0) m_ovf = 1'b1;
        else                exp_q.push_back(e);
      end
      if (w != exp_w(RESOL)) m_hsize = 1'b1;
      m_lines++;
    end else if (clr) begin
      model_clear();
    end
    for (int x = 0; x < w; x++) put(1'b1, 1'b1, 1'b1, pix(x, y));
    ERR_CLR = clr;
    put(1'b0, 1'b1, 1'b1, 24'h0);
    ERR_CLR = 1'b0;
    repeat (3) put(1'b0, 1'b1, 1'b1, 24'h0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_cnt"}, 64'(FRAME_CNT), 64'(m_frames));
    check({tag, "_busy"},      64'(CAP_BUSY),  64'(m_active));
    check({tag, "_hsize_err"}, 64'(HSIZE_ERR), 64'(m_hsize));
    check({tag, "_vsize_err"}, 64'(VSIZE_ERR), 64'(m_vsize));
    check({tag, "_overflow"},  64'(OVERFLOW),  64'(m_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  CAP_DATA, 64'h0);
    check({tag, "_valid"}, 64'(CAP_VALID), 64'h0);
    check({tag, "_sof"},   64'(CAP_SOF), 64'h0);
    check({tag, "_eol"},   64'(CAP_EOL), 64'h0);
    check_flags(tag);
  endtask

  initial begin
    int wait_cnt;
    ARESETN     = 1'b0;
    RESOL       = 2'b00;
    CAP_ENABLE  = 1'b0;
    ERR_CLR     = 1'b0;
    DSP_DE      = 1'b0;
    DSP_HSYNC_X = 1'b1;
    DSP_VSYNC_X = 1'b1;
    {DSP_R, DSP_G, DSP_B} = 24'h0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge DCLK);
    #1;
    ARESETN = 1'b1;
    repeat (3) put(1'b0, 1'b1, 1'b1, 24'h0);

    // Frame 1: VGA, random gaps in CAP_READY, full and odd widths.
    ready_mode = 1;
    CAP_ENABLE = 1'b1;
    repeat (2) put(1'b0, 1'b1, 1'b1, 24'h0);
    check("wait_not_busy", 64'(CAP_BUSY), 64'h0);
    vs_fall();
    send_line(640, 0, 1'b0, 1'b0);
    send_line(13, 1, 1'b0, 1'b0);
    for (int l = 2; l < 6; l++) send_line($urandom_range(1, 24), l, 1'b0, 1'b0);
    vs_fall();
    check_flags("frame1");
    err_clr_pulse();
    check_flags("clr1");

    // Frame 2: exact height with short random lines.
    for (int l = 0; l < 480; l++) send_line($urandom_range(1, 6), l, 1'b0, 1'b0);
    vs_fall();
    check_flags("h480");
    err_clr_pulse();

    // Frame 3: one line short.
    for (int l = 0; l < 479; l++) send_line($urandom_range(1, 6), l, 1'b0, 1'b0);
    vs_fall();
    check_flags("h479");
    err_clr_pulse();

    // Backpressure: a stalled line keeps its first word and drops the rest.
    ready_mode = 0;
    send_line(8, 0, 1'b1, 1'b0);
    ready_mode = 0;
    repeat (4) put(1'b0, 1'b1, 1'b1, 24'h0);
    check_flags("stall");
    err_clr_pulse();
    check_flags("stall_clr");
    send_line(8, 1, 1'b1, 1'b1);
    ready_mode = 0;
    repeat (4) put(1'b0, 1'b1, 1'b1, 24'h0);
    check_flags("clr_vs_drop");

    // Drop CAP_ENABLE mid-frame: the frame still completes, then idle.
    CAP_ENABLE = 1'b0;
    send_line(10, 2, 1'b0, 1'b0);
    vs_fall();
    check_flags("to_idle");

    // XGA with a 1023-pixel line between two full lines.
    RESOL = 2'b01;
    CAP_ENABLE = 1'b1;
    ready_mode = 1;
    vs_fall();
    send_line(1024, 0, 1'b0, 1'b0);
    send_line(1023, 1, 1'b0, 1'b0);
    send_line(1024, 2, 1'b0, 1'b0);
    vs_fall();
    check_flags("xga");

    // Enable raised mid-frame and dropped mid-next-frame (RESOL=11 as VGA).
    CAP_ENABLE = 1'b0;
    send_line(6, 0, 1'b0, 1'b0);
    vs_fall();
    err_clr_pulse();
    RESOL = 2'b11;
    send_line(6, 0, 1'b0, 1'b0);
    CAP_ENABLE = 1'b1;
    send_line(6, 1, 1'b0, 1'b0);
    check_flags("no_capture_before_vs");
    vs_fall();
    send_line(640, 0, 1'b0, 1'b0);
    send_line(3, 1, 1'b0, 1'b0);
    CAP_ENABLE = 1'b0;
    send_line(5, 2, 1'b0, 1'b0);
    vs_fall();
    check_flags("one_frame");

    // Reset mid-line, then recover at a fresh VSYNC fall.
    ready_mode = 0;
    CAP_ENABLE = 1'b1;
    send_line(4, 0, 1'b0, 1'b0);
    vs_fall();
    put(1'b0, 1'b1, 1'b1, 24'h0);
    put(1'b0, 1'b1, 1'b1, 24'h0);
    exp_q.push_back('{data: {8'h00, pix(1, 7), 8'h00, pix(0, 7)}, sof: m_sof_arm, eol: 1'b0});
    m_sof_arm = 1'b0;
    put(1'b1, 1'b1, 1'b1, pix(0, 7));
    put(1'b1, 1'b1, 1'b1, pix(1, 7));
    put(1'b1, 1'b1, 1'b1, pix(2, 7));
    @(negedge DCLK);
    #1;
    ARESETN = 1'b0;
    m_active = 1'b0;
    m_frames = 8'd0;
    m_lines  = 0;
    model_clear();
    #3;
    check_reset_outputs("mid_reset");
    DSP_DE = 1'b0;
    @(posedge DCLK);
    #1;
    ARESETN = 1'b1;
    repeat (3) put(1'b0, 1'b1, 1'b1, 24'h0);
    send_line(4, 0, 1'b0, 1'b0);
    check_flags("post_reset_wait");
    vs_fall();
    send_line(4, 1, 1'b0, 1'b0);
    send_line(6, 2, 1'b0, 1'b0);
    vs_fall();
    check_flags("post_reset_frame");

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 200) begin
      put(1'b0, 1'b1, 1'b1, 24'h0);
      wait_cnt++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
